// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: XLEN, instruction and
// buffer-entry types, default reset PC and a counter-width helper.
package fetch_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] instr_t;
    typedef logic [XLEN-1:0] addr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

    localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

    // Counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect and decode side.
// master = fetch unit, slave = memory/execute/decode environment.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic   imem_req;
    addr_t  imem_addr;
    logic   imem_gnt;
    logic   imem_rvalid;
    instr_t imem_rdata;
    logic   redirect_valid;
    addr_t  redirect_pc;
    logic   instr_valid;
    logic   instr_ready;
    instr_t instruction;
    addr_t  instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic   fetch_fault;
`endif

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instruction, instr_pc,
        input  instr_ready
`ifdef FETCH_MISALIGN_CHECK_EN
        , output fetch_fault
`endif
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instruction, instr_pc,
        output instr_ready
`ifdef FETCH_MISALIGN_CHECK_EN
        , input fetch_fault
`endif
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: shift-register FIFO of fetch entries; head is entry 0, so the
// head output comes straight from a register. Ports: flush/push/pop, count.
module fetch_fifo import fetch_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  wdata_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] wr_idx;

    // Write slot accounts for the shift caused by a same-cycle pop.
    assign wr_idx = cnt_q - CW'(pop_i);

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            if (pop_i) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end
            if (push_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == CW'(i)) begin
                        mem_d[i] = wdata_i;
                    end
                end
            end
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign head_o  = mem_q[0];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential imem fetches, buffers in-order
// responses, handles redirects. Ports: clk, rst (sync, active-low), bus.
// Optional macro FETCH_MISALIGN_CHECK_EN adds fetch_fault on misaligned redirect.
module instr_fetch_unit import fetch_pkg::*; #(
    parameter addr_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int    FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam int CW = cnt_width(FIFO_DEPTH);

    addr_t         pc_q, pc_d;
    addr_t         resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   occ;
    addr_t         tgt_pc;
    logic          redir, faulted;
    logic          gnt_ok, rsp, push, pop;
    fetch_entry_t  head, wentry;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign tgt_pc  = bus.redirect_pc;
    assign fault_d = redir ? (tgt_pc[1:0] != 2'b00) : fault_q;
    assign faulted = fault_q;

    always_ff @(posedge clk) begin
        if (!rst) fault_q <= 1'b0;
        else      fault_q <= fault_d;
    end

    assign bus.fetch_fault = fault_q;
    // resp_pc_q holds the faulting target while faulted.
    assign bus.instr_pc    = fault_q ? resp_pc_q : head.pc;
`else
    assign tgt_pc       = bus.redirect_pc & ~addr_t'(3);
    assign faulted      = 1'b0;
    assign bus.instr_pc = head.pc;
`endif

    assign redir = bus.redirect_valid;
    assign pop   = bus.instr_valid & bus.instr_ready;

    assign bus.instr_valid = rst & ~redir & ~faulted
                           & (fifo_cnt != '0);

    // Reserve a buffer slot for every in-flight fetch.
    assign occ = {1'b0, fifo_cnt} + {1'b0, outstanding_q}
               - (CW+1)'(pop);

    assign bus.imem_req  = rst & ~redir & ~faulted
                         & (occ < (CW+1)'(FIFO_DEPTH));
    assign bus.imem_addr = pc_q;

    assign gnt_ok = bus.imem_req & bus.imem_gnt;
    assign rsp    = bus.imem_rvalid & (outstanding_q != '0);
    assign push   = rsp & (discard_q == '0) & ~redir;

    assign wentry = '{instr: bus.imem_rdata, pc: resp_pc_q};

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(gnt_ok) - CW'(rsp);
        if (redir) begin
            pc_d      = tgt_pc;
            resp_pc_d = tgt_pc;
            // A response returning this cycle is already accounted for.
            discard_d = outstanding_q - CW'(rsp);
        end else begin
            if (gnt_ok) pc_d = pc_q + 32'd4;
            if (push)   resp_pc_d = resp_pc_q + 32'd4;
            if (rsp && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redir),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fifo_cnt)
    );

    assign bus.instruction = head.instr;

endmodule
